// File: rtl/full_adder_pkg.sv
// Shared constants and result type for the registered ripple-carry adder.
// Optional overflow output is controlled by FULL_ADDER_OVERFLOW_EN.
package full_adder_pkg;

  localparam int WIDTH_DEFAULT = 1;
  localparam int WIDTH_MAX     = 64;

  // {carry, sum} at the default operand width
  typedef logic [WIDTH_DEFAULT:0] result_t;

  // Widest result any legal instance can produce
  typedef logic [WIDTH_MAX:0] result_max_t;

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full-adder cell; one link of the ripple carry chain.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder with valid qualifier, one-cycle latency.
// Define FULL_ADDER_OVERFLOW_EN to add the registered two's-complement overflow output.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
`ifdef FULL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  // Plain ripple: each cell's carry-out feeds the next cell's carry-in
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_bit u_bit (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  // Result registers load only on valid input, so idle-cycle operands never reach the outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
`ifdef FULL_ADDER_OVERFLOW_EN
      overflow  <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum      <= s;
        carry    <= c[WIDTH];
`ifdef FULL_ADDER_OVERFLOW_EN
        overflow <= c[WIDTH] ^ c[WIDTH-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed self-checking bench for full_adder at WIDTH = 1, 8 and 16.
// Overflow checks are compiled in only when FULL_ADDER_OVERFLOW_EN is defined.
module tb_full_adder;

  logic clk;
  logic rst;

  logic [0:0]  a1, b1, sum1;
  logic        cin1, v1, carry1, ov1_valid;
  logic [7:0]  a8, b8, sum8;
  logic        cin8, v8, carry8, ov8_valid;
  logic [15:0] a16, b16, sum16;
  logic        cin16, v16, carry16, ov16_valid;
`ifdef FULL_ADDER_OVERFLOW_EN
  logic        ovf1, ovf8, ovf16;
`endif

  int checks;
  int failures;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .in_valid(v1),
    .sum(sum1), .carry(carry1), .out_valid(ov1_valid)
`ifdef FULL_ADDER_OVERFLOW_EN
    , .overflow(ovf1)
`endif
  );

  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .in_valid(v8),
    .sum(sum8), .carry(carry8), .out_valid(ov8_valid)
`ifdef FULL_ADDER_OVERFLOW_EN
    , .overflow(ovf8)
`endif
  );

  full_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16), .in_valid(v16),
    .sum(sum16), .carry(carry16), .out_valid(ov16_valid)
`ifdef FULL_ADDER_OVERFLOW_EN
    , .overflow(ovf16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  exp1 [8];
    logic        expov1 [8];
    logic [16:0] exp16;
    logic        expov16;
    logic [2:0]  vec;

    exp1   = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    expov1 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    checks = 0;
    failures = 0;
    rst = 1'b0;
    a1 = '0; b1 = '0; cin1 = 0; v1 = 0;
    a8 = '0; b8 = '0; cin8 = 0; v8 = 0;
    a16 = '0; b16 = '0; cin16 = 0; v16 = 0;

    // Asynchronous reset with no clock edge involved
    #2 rst = 1'b1;
    #1;
    chk("rst_sum1", 64'(sum1), 64'd0);
    chk("rst_valid1", 64'(ov1_valid), 64'd0);
    chk("rst_sum8", 64'(sum8), 64'd0);
    chk("rst_carry8", 64'(carry8), 64'd0);
    chk("rst_valid16", 64'(ov16_valid), 64'd0);
`ifdef FULL_ADDER_OVERFLOW_EN
    chk("rst_ovf8", 64'(ovf8), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // WIDTH=1 exhaustive sweep, back-to-back
    for (int i = 0; i < 8; i++) begin
      vec  = 3'(i);
      a1   = vec[2];
      b1   = vec[1];
      cin1 = vec[0];
      v1   = 1'b1;
      after_edge();
      chk($sformatf("w1_sum_%0d", i), 64'({carry1, sum1}), 64'(exp1[i]));
      chk($sformatf("w1_valid_%0d", i), 64'(ov1_valid), 64'd1);
`ifdef FULL_ADDER_OVERFLOW_EN
      chk($sformatf("w1_ovf_%0d", i), 64'(ovf1), 64'(expov1[i]));
`endif
    end
    v1 = 1'b0;

    // WIDTH=8 directed vectors
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; v8 = 1'b1;
    after_edge();
    chk("w8_ff_00_1_sum", 64'(sum8), 64'h00);
    chk("w8_ff_00_1_carry", 64'(carry8), 64'd1);
`ifdef FULL_ADDER_OVERFLOW_EN
    chk("w8_ff_00_1_ovf", 64'(ovf8), 64'd0);
`endif
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
    after_edge();
    chk("w8_7f_01_sum", 64'(sum8), 64'h80);
    chk("w8_7f_01_carry", 64'(carry8), 64'd0);
`ifdef FULL_ADDER_OVERFLOW_EN
    chk("w8_7f_01_ovf", 64'(ovf8), 64'd1);
`endif
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    after_edge();
    chk("w8_allones_sum", 64'(sum8), 64'hFF);
    chk("w8_allones_carry", 64'(carry8), 64'd1);
`ifdef FULL_ADDER_OVERFLOW_EN
    chk("w8_allones_ovf", 64'(ovf8), 64'd0);
`endif
    a8 = 8'h10; b8 = 8'h02; cin8 = 1'b0;
    after_edge();
    chk("w8_hold_load_sum", 64'(sum8), 64'h12);
    chk("w8_hold_load_valid", 64'(ov8_valid), 64'd1);

    // Idle cycles: random and then X operands must not disturb the held result
    v8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      cin8 = 1'($urandom);
      if (i == 2) begin
        a8 = 'x; b8 = 'x; cin8 = 1'bx;
      end
      after_edge();
      chk($sformatf("w8_hold_sum_%0d", i), 64'(sum8), 64'h12);
      chk($sformatf("w8_hold_carry_%0d", i), 64'(carry8), 64'd0);
      chk($sformatf("w8_hold_valid_%0d", i), 64'(ov8_valid), 64'd0);
    end

    // Reset asserted mid-cycle during a stream
    a8 = 8'h21; b8 = 8'h10; cin8 = 1'b0; v8 = 1'b1;
    after_edge();
    chk("w8_pre_rst_sum", 64'(sum8), 64'h31);
    a8 = 8'h05; b8 = 8'h05;
    #2 rst = 1'b1;
    #1;
    chk("w8_midrst_sum", 64'(sum8), 64'h00);
    chk("w8_midrst_valid", 64'(ov8_valid), 64'd0);
    after_edge();
    chk("w8_inrst_valid", 64'(ov8_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    v8 = 1'b0;
    after_edge();
    chk("w8_postrst_valid", 64'(ov8_valid), 64'd0);
    chk("w8_postrst_sum", 64'(sum8), 64'h00);
    a8 = 8'h40; b8 = 8'h02; cin8 = 1'b1; v8 = 1'b1;
    after_edge();
    chk("w8_first_after_rst_sum", 64'(sum8), 64'h43);
    chk("w8_first_after_rst_valid", 64'(ov8_valid), 64'd1);
    v8 = 1'b0;

    // WIDTH=16 all-ones boundary
    a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1; v16 = 1'b1;
    after_edge();
    chk("w16_allones", 64'({carry16, sum16}), 64'h1FFFF);

    // WIDTH=16 random back-to-back stream against a+b+cin
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    for (int k = 0; k < 10000; k++) begin
      exp16   = {1'b0, a16} + {1'b0, b16} + {16'd0, cin16};
      expov16 = (a16[15] == b16[15]) && (exp16[15] != a16[15]);
      after_edge();
      chk("w16_rand_result", 64'({carry16, sum16}), 64'(exp16));
      chk("w16_rand_valid", 64'(ov16_valid), 64'd1);
`ifdef FULL_ADDER_OVERFLOW_EN
      chk("w16_rand_ovf", 64'(ovf16), 64'(expov16));
`endif
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    end
    v16 = 1'b0;
    after_edge();
    chk("w16_stream_end_valid", 64'(ov16_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
